mmio_stream_bridge: RTL and testbench
=====================================

# mmio_stream_bridge

Memory-mapped bridge between the CPU data bus and NUM_CH independent byte-stream channels (e.g. USB CDC endpoints, UART). Each channel has its own RX and TX FIFOs of parametrised depth, sticky error flags, interrupt enables and occupancy readback. The CPU top decodes nothing itself: it drives the ALU address and the load/store strobes, and muxes data_o onto the bus when hit_o is high. It is the parametrised successor of the single-channel USB FIFO interface.

## Interface
- NUM_CH, 1, number of channels (1..8)
- DEPTH, 16, entries per RX and per TX FIFO; power of two, 2..128
- BASE_ADDR, 32'h0002_0000, byte address of channel 0 register 0
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- addr_i  in  32  bus byte address
- r_en_i  in  1  load strobe, one access per cycle
- wr_en_i  in  1  store strobe
- data_i  in  8  store data (low byte of rs2)
- data_o  out  8  load data, combinational; 0 when hit_o low
- hit_o  out  1  addr_i within [BASE_ADDR, BASE_ADDR+4*NUM_CH)
- irq_o  out  NUM_CH  per-channel interrupt
- tx_data_o  out  8*NUM_CH  channel c at [8c+7:8c]
- tx_valid_o  out  NUM_CH  TX FIFO non-empty
- tx_ready_i  in  NUM_CH  sink accepts
- rx_data_i  in  8*NUM_CH  channel c at [8c+7:8c]
- rx_valid_i  in  NUM_CH  source offers byte
- rx_ready_o  out  NUM_CH  RX FIFO not full

## Operation
- Channel c = (addr_i - BASE_ADDR) >> 2; reg = addr_i[1:0]. Accesses with hit_o low have no effect.
- reg 0 DATA: load returns RX head and pops; load on empty RX returns 8'h00, no pop, sets RXUF. Store pushes data_i to TX; store on full TX drops the byte, sets TXOF.
- reg 1 STATUS (load): bit0 rx_nonempty, bit1 tx_not_full, bit2 tx_empty, bit3 RXUF, bit4 TXOF, bits7:5 zero. Store: write-1-to-clear bits 3/4; bit5=1 flushes RX, bit6=1 flushes TX.
- reg 2 IRQ_EN (load/store, 3 bits, upper bits read 0): bit0 RX non-empty, bit1 TX empty, bit2 error (RXUF|TXOF).
- reg 3 COUNT (load): RX occupancy, 0..DEPTH. Store ignored.
- irq_o[c] = (en0 & rx_nonempty) | (en1 & tx_empty) | (en2 & (RXUF|TXOF)).
- FIFOs: circular buffers, pointers log2(DEPTH) bits wrap silently, occupancy counter log2(DEPTH)+1 bits.
- RX accept when rx_valid_i & rx_ready_o; TX send when tx_valid_o & tx_ready_i; tx_data_o = TX head.
- Full/empty judged on pre-edge state: a CPU pop on a full RX does not enable acceptance in the same cycle (rx_ready_o low); a store to a full TX is dropped even if the sink pops the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged, both take effect.
- Flush priority: RX flush discards any byte accepted in the same cycle (handshake still completes); TX flush counts a byte handshaked in the same cycle as sent. Flush does not clear sticky flags.
- Store to STATUS that both clears a flag and the same cycle's event would set it: set wins.

## Timing
- Reset: FIFOs empty, flags 0, IRQ_EN 0; tx_valid_o 0, rx_ready_o all 1, irq_o 0, data_o 0, hit_o follows addr_i.
- data_o, hit_o combinational from addr_i and registered state; zero-wait load, pop at the same clock edge.
- Store takes effect at the clock edge; a TX byte stored at edge n shows tx_valid_o high after edge n.
- RX byte accepted at edge n is readable by a load in cycle n+1; COUNT and STATUS update after edge n.
- irq_o is a function of registers only; updates one cycle after the causing event.
- Reset asserted mid-transfer: all state cleared asynchronously, in-flight bytes lost.

## Test plan
- Reset, NUM_CH=2, DEPTH=4: tx_valid_o=00, rx_ready_o=11, STATUS ch0 reads 8'h06, COUNT 0.
- Push 4 RX bytes 8'hA1..A4 on ch1: rx_ready_o[1] low after 4th; COUNT=4; loads of DATA at BASE+4 return A1,A2,A3,A4, 5th load returns 00 and STATUS bit3 set; write 8'h08 to STATUS clears it.
- Store 5 bytes to ch0 DATA with tx_ready_i=0: 5th dropped, TXOF set; release tx_ready_i: 4 bytes emerge in order, then tx_valid_o falls, tx_empty=1.
- Full RX with rx_valid_i high and CPU pop same cycle: byte not accepted that cycle, accepted next; order preserved across pointer wrap (12 bytes through DEPTH=4).
- IRQ_EN ch0=3'b001: irq_o[0] rises cycle after RX accept, falls cycle after last pop; en=3'b100 with RXUF set -> irq high until cleared.
- RX flush coincident with an accepted byte: COUNT=0 next cycle, byte discarded; reset pulse mid-TX stream -> tx_valid_o 0 immediately.

Source files
------------

// File: rtl/mmio_stream_bridge.sv
// Memory-mapped bridge between the CPU data bus and NUM_CH byte-stream
// channels, each with RX/TX FIFOs, sticky error flags and interrupt enables.

module mmio_stream_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A flush discards everything, including a byte pushed this cycle
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

module mmio_stream_bridge #(
    parameter int          NUM_CH    = 1,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [31:0]           addr_i,
    input  logic                  r_en_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            data_i,
    output logic [7:0]            data_o,
    output logic                  hit_o,
    output logic [NUM_CH-1:0]     irq_o,
    output logic [8*NUM_CH-1:0]   tx_data_o,
    output logic [NUM_CH-1:0]     tx_valid_o,
    input  logic [NUM_CH-1:0]     tx_ready_i,
    input  logic [8*NUM_CH-1:0]   rx_data_i,
    input  logic [NUM_CH-1:0]     rx_valid_i,
    output logic [NUM_CH-1:0]     rx_ready_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] off;
    logic [29:0] ch_idx;
    logic [1:0]  reg_sel;
    logic        ld_data;
    logic        st_data;
    logic        st_stat;
    logic        st_irqen;
    logic [7:0]  rd_val [NUM_CH];

    // BASE_ADDR is word aligned, so the offset's low bits equal addr_i[1:0]
    assign off      = addr_i - BASE_ADDR;
    assign ch_idx   = off[31:2];
    assign reg_sel  = off[1:0];
    assign hit_o    = (off < 32'(4 * NUM_CH));
    assign ld_data  = r_en_i  & hit_o & (reg_sel == 2'd0);
    assign st_data  = wr_en_i & hit_o & (reg_sel == 2'd0);
    assign st_stat  = wr_en_i & hit_o & (reg_sel == 2'd1);
    assign st_irqen = wr_en_i & hit_o & (reg_sel == 2'd2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          sel;
        logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
        logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
        logic [7:0]    rx_rdata, tx_rdata;
        logic [CW-1:0] rx_cnt, tx_cnt;
        logic          uf_set, of_set;
        logic          rxuf_q, rxuf_d;
        logic          txof_q, txof_d;
        logic [2:0]    en_q, en_d;
        logic [7:0]    cnt8;
        logic [7:0]    rd;

        assign sel = (ch_idx == 30'(c));

        assign rx_push  = rx_valid_i[c] & ~rx_full;
        assign rx_pop   = ld_data & sel & ~rx_empty;
        assign rx_flush = st_stat & sel & data_i[5];
        assign uf_set   = ld_data & sel & rx_empty;

        assign tx_push  = st_data & sel & ~tx_full;
        assign tx_pop   = tx_ready_i[c] & ~tx_empty;
        assign tx_flush = st_stat & sel & data_i[6];
        assign of_set   = st_data & sel & tx_full;

        mmio_stream_fifo #(.DEPTH(DEPTH)) u_rx (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .push_i  (rx_push),
            .pop_i   (rx_pop),
            .flush_i (rx_flush),
            .wdata_i (rx_data_i[8*c +: 8]),
            .rdata_o (rx_rdata),
            .full_o  (rx_full),
            .empty_o (rx_empty),
            .count_o (rx_cnt)
        );

        mmio_stream_fifo #(.DEPTH(DEPTH)) u_tx (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .push_i  (tx_push),
            .pop_i   (tx_pop),
            .flush_i (tx_flush),
            .wdata_i (data_i),
            .rdata_o (tx_rdata),
            .full_o  (tx_full),
            .empty_o (tx_empty),
            .count_o (tx_cnt)
        );

        // Setting events win over a same-cycle write-1-to-clear
        always_comb begin
            rxuf_d = uf_set | (rxuf_q & ~(st_stat & sel & data_i[3]));
            txof_d = of_set | (txof_q & ~(st_stat & sel & data_i[4]));
            en_d   = (st_irqen & sel) ? data_i[2:0] : en_q;
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rxuf_q <= 1'b0;
                txof_q <= 1'b0;
                en_q   <= 3'b000;
            end else begin
                rxuf_q <= rxuf_d;
                txof_q <= txof_d;
                en_q   <= en_d;
            end
        end

        always_comb begin
            cnt8 = '0;
            cnt8[CW-1:0] = rx_cnt;
        end

        always_comb begin
            rd = '0;
            unique case (reg_sel)
                2'd0: rd = rx_empty ? 8'h00 : rx_rdata;
                2'd1: rd = {3'b000, txof_q, rxuf_q, tx_empty,
                            ~tx_full, ~rx_empty};
                2'd2: rd = {5'b00000, en_q};
                2'd3: rd = cnt8;
                default: rd = '0;
            endcase
        end

        assign rd_val[c]         = rd;
        assign rx_ready_o[c]     = ~rx_full;
        assign tx_valid_o[c]     = ~tx_empty;
        assign tx_data_o[8*c +: 8] = tx_rdata;
        assign irq_o[c] = (en_q[0] & ~rx_empty) | (en_q[1] & tx_empty)
                        | (en_q[2] & (rxuf_q | txof_q));
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_o && ch_idx == 30'(i)) data_o = rd_val[i];
        end
    end
endmodule

// File: tb/tb_mmio_stream_bridge.sv
// Scoreboard bench for mmio_stream_bridge: queue-based reference model,
// directed scenarios followed by randomized bus and stream traffic.

module tb_mmio_stream_bridge;
    localparam int          NCH  = 2;
    localparam int          DEP  = 4;
    localparam logic [31:0] BASE = 32'h0002_0000;

    logic            clk;
    logic            rstn;
    logic [31:0]     addr;
    logic            r_en, wr_en;
    logic [7:0]      din, dout;
    logic            hit;
    logic [NCH-1:0]  irq, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [8*NCH-1:0] tx_data, rx_data;

    mmio_stream_bridge #(
        .NUM_CH(NCH), .DEPTH(DEP), .BASE_ADDR(BASE)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .addr_i     (addr),
        .r_en_i     (r_en),
        .wr_en_i    (wr_en),
        .data_i     (din),
        .data_o     (dout),
        .hit_o      (hit),
        .irq_o      (irq),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            re;
        logic            hit;
        logic [7:0]      data;
        logic [NCH-1:0]  rdy;
        logic [NCH-1:0]  vld;
        logic [NCH-1:0]  irq;
        logic [8*NCH-1:0] txd;
    } rec_t;

    rec_t sb[$];

    logic [7:0] mrx [NCH][$];
    logic [7:0] mtx [NCH][$];
    logic       m_uf [NCH];
    logic       m_of [NCH];
    logic [2:0] m_en [NCH];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input int rg);
        return BASE + 32'(4 * ch + rg);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            mrx[ch].delete();
            mtx[ch].delete();
            m_uf[ch] = 1'b0;
            m_of[ch] = 1'b0;
            m_en[ch] = 3'b000;
        end
    endtask

    // Drive one cycle, record expectations from pre-edge model, advance model
    task automatic step(input logic re, input logic we,
                        input logic [31:0] a, input logic [7:0] wd,
                        input logic [NCH-1:0] rxv,
                        input logic [8*NCH-1:0] rxd,
                        input logic [NCH-1:0] txr);
        rec_t r;
        logic [31:0] off;
        logic h, sel, rfull, tfull, rne, clr_uf, clr_of, stw;
        int c, rg;
        r_en = re; wr_en = we; addr = a; din = wd;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        off = a - BASE;
        h = off < 32'(4 * NCH);
        c = int'(off >> 2);
        rg = int'(a[1:0]);
        r.re = re; r.hit = h; r.data = 8'h00;
        r.rdy = '0; r.vld = '0; r.irq = '0; r.txd = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            r.rdy[ch] = mrx[ch].size() < DEP;
            r.vld[ch] = mtx[ch].size() > 0;
            r.irq[ch] = (m_en[ch][0] && mrx[ch].size() > 0)
                     || (m_en[ch][1] && mtx[ch].size() == 0)
                     || (m_en[ch][2] && (m_uf[ch] || m_of[ch]));
            if (r.vld[ch]) r.txd[8*ch +: 8] = mtx[ch][0];
        end
        if (re && h) begin
            case (rg)
                0: r.data = (mrx[c].size() > 0) ? mrx[c][0] : 8'h00;
                1: r.data = {3'b000, m_of[c], m_uf[c], mtx[c].size() == 0,
                             mtx[c].size() < DEP, mrx[c].size() > 0};
                2: r.data = {5'b00000, m_en[c]};
                default: r.data = 8'(mrx[c].size());
            endcase
        end
        sb.push_back(r);
        for (int ch = 0; ch < NCH; ch++) begin
            sel   = h && (c == ch);
            rfull = mrx[ch].size() == DEP;
            tfull = mtx[ch].size() == DEP;
            rne   = mrx[ch].size() > 0;
            stw   = we && sel && rg == 1;
            clr_uf = stw && wd[3];
            clr_of = stw && wd[4];
            if (mtx[ch].size() > 0 && txr[ch]) void'(mtx[ch].pop_front());
            if (we && sel && rg == 0 && !tfull) mtx[ch].push_back(wd);
            if (re && sel && rg == 0 && rne) void'(mrx[ch].pop_front());
            if (rxv[ch] && !rfull) mrx[ch].push_back(rxd[8*ch +: 8]);
            if (stw && wd[5]) mrx[ch].delete();
            if (stw && wd[6]) mtx[ch].delete();
            m_uf[ch] = (re && sel && rg == 0 && !rne) || (m_uf[ch] && !clr_uf);
            m_of[ch] = (we && sel && rg == 0 && tfull) || (m_of[ch] && !clr_of);
            if (we && sel && rg == 2) m_en[ch] = wd[2:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] txr);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 8'h00, '0, '0, txr);
    endtask

    always @(negedge clk) begin : monitor
        rec_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("hit", 32'(hit), 32'(r.hit));
            if (r.re && r.hit) chk($sformatf("load@%0h", addr), 32'(dout), 32'(r.data));
            if (!r.hit) chk("data_nohit", 32'(dout), 32'h0);
            chk("rx_ready", 32'(rx_ready), 32'(r.rdy));
            chk("tx_valid", 32'(tx_valid), 32'(r.vld));
            chk("irq", 32'(irq), 32'(r.irq));
            for (int ch = 0; ch < NCH; ch++)
                if (r.vld[ch])
                    chk($sformatf("tx_data%0d", ch),
                        32'(tx_data[8*ch +: 8]), 32'(r.txd[8*ch +: 8]));
        end
    end

    initial begin
        int k;
        logic acc;
        logic [31:0] a;
        logic [7:0] wd;
        int kind, cs, rg;
        rstn = 1'b0; addr = '0; r_en = 0; wr_en = 0; din = '0;
        rx_valid = '0; rx_data = '0; tx_ready = '0;
        model_reset();
        #23 rstn = 1'b1;
        @(posedge clk); #1;

        // Reset state
        idle(2, '0);
        step(1, 0, ra(0, 1), 8'h00, '0, '0, '0);
        step(1, 0, ra(0, 3), 8'h00, '0, '0, '0);
        chk("reset_status_model", 32'({3'b0, m_of[0], m_uf[0], mtx[0].size() == 0,
            mtx[0].size() < DEP, mrx[0].size() > 0}), 32'h06);

        // Fill ch1 RX, drain past empty, clear RXUF
        for (int i = 0; i < 4; i++)
            step(0, 0, 32'h0, 8'h00, 2'b10, {8'hA1 + 8'(i), 8'h00}, '0);
        step(0, 0, 32'h0, 8'h00, 2'b10, {8'hA5, 8'h00}, '0);
        step(1, 0, ra(1, 3), 8'h00, '0, '0, '0);
        for (int i = 0; i < 5; i++) step(1, 0, ra(1, 0), 8'h00, '0, '0, '0);
        step(1, 0, ra(1, 1), 8'h00, '0, '0, '0);
        step(0, 1, ra(1, 1), 8'h08, '0, '0, '0);
        step(1, 0, ra(1, 1), 8'h00, '0, '0, '0);

        // TX overflow then drain
        for (int i = 0; i < 5; i++)
            step(0, 1, ra(0, 0), 8'hC0 + 8'(i), '0, '0, '0);
        step(1, 0, ra(0, 1), 8'h00, '0, '0, '0);
        idle(6, 2'b01);
        step(1, 0, ra(0, 1), 8'h00, '0, '0, '0);
        step(0, 1, ra(0, 1), 8'h18, '0, '0, '0);

        // Full RX with coincident pop, 12 bytes through a 4-deep FIFO
        k = 0;
        for (int i = 0; i < 30; i++) begin
            acc = mrx[0].size() < DEP;
            step(i >= 4, 0, ra(0, 0), 8'h00, 2'(k < 12),
                 {8'h00, 8'hB0 + 8'(k)}, '0);
            if (acc && k < 12) k++;
        end
        chk("wrap_all_fed", 32'(k), 32'd12);
        step(0, 1, ra(0, 1), 8'h18, '0, '0, '0);

        // Interrupt enables
        step(0, 1, ra(0, 2), 8'h01, '0, '0, '0);
        step(0, 0, 32'h0, 8'h00, 2'b01, 16'h0055, '0);
        idle(2, '0);
        step(1, 0, ra(0, 0), 8'h00, '0, '0, '0);
        idle(2, '0);
        step(0, 1, ra(0, 2), 8'h04, '0, '0, '0);
        step(1, 0, ra(0, 0), 8'h00, '0, '0, '0);
        idle(2, '0);
        step(0, 1, ra(0, 1), 8'h08, '0, '0, '0);
        idle(2, '0);
        step(1, 0, ra(0, 2), 8'h00, '0, '0, '0);

        // RX flush coincident with an accepted byte
        step(0, 0, 32'h0, 8'h00, 2'b01, 16'h0011, '0);
        step(0, 1, ra(0, 1), 8'h20, 2'b01, 16'h0022, '0);
        step(1, 0, ra(0, 3), 8'h00, '0, '0, '0);
        step(1, 0, ra(0, 1), 8'h00, '0, '0, '0);

        // Reset pulse mid TX stream
        for (int i = 0; i < 3; i++)
            step(0, 1, ra(0, 0), 8'hD0 + 8'(i), '0, '0, '0);
        step(0, 0, 32'h0, 8'h00, '0, '0, 2'b01);
        #2;
        chk("pre_reset_tx_valid", 32'(tx_valid[0]), 32'(mtx[0].size() > 0));
        rstn = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h3);
        chk("rst_irq", 32'(irq), 32'h0);
        model_reset();
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        step(1, 0, ra(0, 1), 8'h00, '0, '0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 9);
            cs = $urandom_range(0, 5);
            rg = $urandom_range(0, 3);
            if (cs < 4) a = ra(cs % 2, rg);
            else if (cs == 4) a = BASE - 32'd4 + 32'(rg);
            else a = ra(NCH, rg);
            wd = 8'($urandom);
            if (rg == 1 && $urandom_range(0, 9) != 0) wd[6:5] = 2'b00;
            step(kind < 4, kind >= 4 && kind < 7, a, wd,
                 2'($urandom), 16'($urandom),
                 ((i / 150) % 2 == 1) ? 2'($urandom) : 2'b00);
        end
        idle(2, 2'b11);
        @(negedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
